// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: WIDTH-bit a-b computed one 4-bit ripple slice per cycle, LSB first
//   clk, rst      : clock, asynchronous active-high reset
//   start, a, b   : request and operands, accepted while idle
//   busy, done    : computing / one-cycle completion pulse
//   diff          : a - b modulo 2^WIDTH
//   borrow        : a < b unsigned
//   overflow      : signed overflow of a - b
module nibble_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);
  localparam int N  = WIDTH / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry, co, last;
  logic [WIDTH-1:0] a_r, b_r;
  logic [3:0]       s;
  assign last = idx == IW'(N - 1);
  // operand copies shift right each slice, so the active nibble is always [3:0]
  always_comb begin
    logic cc;
    cc = carry;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a_r[i] ^ ~b_r[i] ^ cc;
      cc   = (a_r[i] & ~b_r[i]) | (cc & (a_r[i] ^ ~b_r[i]));
    end
    co = cc;
  end
  always_comb state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_r      <= a;
          b_r      <= b;
          idx      <= '0;
          carry    <= 1'b1;
          busy     <= 1'b1;
          diff     <= '0;
          borrow   <= 1'b0;
          overflow <= 1'b0;
        end
      end else begin
        a_r   <= a_r >> 4;
        b_r   <= b_r >> 4;
        carry <= co;
        idx   <= idx + 1'b1;
        for (int k = 0; k < N; k++)
          if (idx == IW'(k)) diff[4*k +: 4] <= s;
        // on the last slice a_r[3]/b_r[3] are the operand sign bits and s[3] the result sign
        if (last) begin
          idx      <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          borrow   <= ~co;
          overflow <= (a_r[3] != b_r[3]) && (s[3] != a_r[3]);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed and randomized checks of nibble_serial_subtractor against an arithmetic model
module tb_nibble_serial_subtractor;
  localparam int W = 8;
  localparam int N = W / 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, overflow;
  logic [W-1:0] diff;
  int           checks = 0, failures = 0;
  logic [W-1:0] last_d;
  logic         last_b, last_o;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic br, output logic ov);
    int r;
    d  = W'(int'(x) - int'(y));
    br = x < y;
    r  = int'($signed(x)) - int'($signed(y));
    ov = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_borrow"}, borrow, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit inj);
    logic [W-1:0] ed, m;
    logic         eb, eo;
    model(oa, ob, ed, eb, eo);
    @(negedge clk);
    start = 1'b1; a = oa; b = ob;
    @(posedge clk); #1;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_diff", diff, 0);
    chk("start_borrow", borrow, 0);
    chk("start_ovf", overflow, 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      start = inj && k == 0;
      a = start ? '1 : W'($urandom);
      b = start ? '1 : W'($urandom);
      @(posedge clk); #1;
      m = W'((1 << (4 * (k + 1))) - 1);
      if (k < N - 1) begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_partial", diff, ed & m);
      end else begin
        chk("fin_busy", busy, 0);
        chk("fin_done", done, 1);
        chk("fin_diff", diff, ed);
        chk("fin_borrow", borrow, eb);
        chk("fin_ovf", overflow, eo);
      end
    end
    start = 1'b0;
    last_d = ed; last_b = eb; last_o = eo;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_diff", diff, last_d);
    chk("hold_borrow", borrow, last_b);
    chk("hold_ovf", overflow, last_o);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'($urandom); a = W'($urandom); b = W'($urandom);
      zero_outs("reset");
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    op(8'h5A, 8'h23, 0);
    idle_cycle();
    op(8'h00, 8'h01, 0);
    op(8'h10, 8'h20, 0);
    idle_cycle();
    op(8'h80, 8'h01, 0);
    op(8'h7F, 8'hFF, 0);
    idle_cycle();
    op(8'h5A, 8'h23, 1);
    op(8'h03, 8'h05, 0);
    idle_cycle();
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h23;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_partial", diff, 8'h07);
    #2 rst = 1'b1;
    #1 zero_outs("async_rst");
    @(negedge clk);
    zero_outs("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
      chk("idle_after_rst", busy, 0);
    end
    op(8'h44, 8'h44, 0);
    for (int i = 0; i < 24; i++) begin
      op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
